argmax_sequencer: RTL and testbench

- Front-end controller for the argmax cell (softmax_cell) at the tail of the inference pipeline.
- Accepts the output-layer score stream over a valid/ready handshake and generates the element index itself.
- Drives the cell's index, value and enable inputs, catches the cell's one-cycle result flag and holds the winning class index on a valid/ready result port.
- Handles stream stalls, short or overlong vectors and result backpressure.

---
 rtl/argmax_sequencer_pkg.sv | 16 +
 rtl/softmax_cell.sv | 49 ++++
 rtl/argmax_sequencer.sv | 152 +++++++++++++++
 tb/tb_argmax_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/argmax_sequencer_pkg.sv
// Shared definitions for the argmax front-end: FSM encoding and default sizes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package argmax_sequencer_pkg;

   localparam int DEFAULT_DATA_WIDTH  = 32;
   localparam int DEFAULT_CELL_AMOUNT = 4;

   typedef enum logic [1:0] {
      S_STREAM  = 2'd0,
      S_FLUSH   = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

endpackage

// File: rtl/softmax_cell.sv
// Running argmax cell: tracks the largest value seen and its index, with the latest tie winning.
// Latency: 1 cycle from enable to output_result; the flag pulses when index CELL_AMOUNT-1 is sampled.
// Backpressure: none; it samples whenever input_enable is high and holds otherwise.
module softmax_cell
   import argmax_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int CELL_AMOUNT = DEFAULT_CELL_AMOUNT
) (
   input  logic                  clk,
   input  logic [DATA_WIDTH-1:0] input_index,
   input  logic [DATA_WIDTH-1:0] input_value,
   input  logic                  input_enable,
   output logic [DATA_WIDTH:0]   output_result
);

   localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(CELL_AMOUNT - 1);

   logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
   logic [DATA_WIDTH-1:0] best_idx_q, best_idx_d;
   logic [DATA_WIDTH:0]   result_q, result_d;

   // Index 0 restarts the search; otherwise an equal-or-larger value takes over.
   always_comb begin
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      result_d   = {1'b0, result_q[DATA_WIDTH-1:0]};
      if (input_enable) begin
         if (input_index == '0) begin
            best_val_d = input_value;
            best_idx_d = '0;
         end else if (best_val_q <= input_value) begin
            best_val_d = input_value;
            best_idx_d = input_index;
         end
         result_d = {(input_index == LAST_IDX), best_idx_d};
      end
   end

   // No reset needed: the first index-0 beat reloads the running maximum.
   always_ff @(posedge clk) begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      result_q   <= result_d;
   end

   assign output_result = result_q;

endmodule

// File: rtl/argmax_sequencer.sv
// Feeds a score stream into the argmax cell with self-generated indices and returns the winning class.
// Latency: res_valid rises 2 cycles after the closing beat is accepted.
// Backpressure: in_ready drops from vector close until the result is taken via res_ready.
module argmax_sequencer
   import argmax_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int CELL_AMOUNT = DEFAULT_CELL_AMOUNT,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  in_value,
   input  logic                   in_last,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_WIDTH-1:0]  cell_index,
   output logic [DATA_WIDTH-1:0]  cell_value,
   output logic                   cell_enable,
   input  logic [DATA_WIDTH:0]    cell_result,
   output logic [DATA_WIDTH-1:0]  res_index,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   err_len,
   output logic                   err_cell,
   input  logic                   err_clr,
   output logic [COUNT_WIDTH-1:0] class_count
);

   localparam logic [DATA_WIDTH-1:0]  LAST_IDX  = DATA_WIDTH'(CELL_AMOUNT - 1);
   localparam logic [DATA_WIDTH-1:0]  IDX_ONE   = DATA_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  idx_q, idx_d;
   logic [DATA_WIDTH-1:0]  last_idx_q, last_idx_d;
   logic [DATA_WIDTH-1:0]  cell_index_q, cell_index_d;
   logic [DATA_WIDTH-1:0]  cell_value_q, cell_value_d;
   logic                   cell_enable_q, cell_enable_d;
   logic [DATA_WIDTH-1:0]  res_index_q, res_index_d;
   logic                   res_valid_q, res_valid_d;
   logic                   err_len_q, err_len_d;
   logic                   err_cell_q, err_cell_d;
   logic [COUNT_WIDTH-1:0] class_count_q, class_count_d;
   logic                   accept;
   logic                   at_last_idx;

   // Next-state and registered-output logic; sticky errors clear first so a new event wins.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      last_idx_d    = last_idx_q;
      cell_index_d  = cell_index_q;
      cell_value_d  = cell_value_q;
      cell_enable_d = 1'b0;
      res_index_d   = res_index_q;
      res_valid_d   = res_valid_q;
      err_len_d     = err_len_q & ~err_clr;
      err_cell_d    = err_cell_q & ~err_clr;
      class_count_d = class_count_q;
      in_ready      = rst_n && (state_q == S_STREAM);
      accept        = in_valid && in_ready;
      at_last_idx   = (idx_q == LAST_IDX);

      case (state_q)
         S_STREAM: begin
            if (accept) begin
               cell_enable_d = 1'b1;
               cell_value_d  = in_value;
               cell_index_d  = idx_q;
               if (in_last || at_last_idx) begin
                  // Forcing the top index makes the cell raise its flag on short vectors too.
                  cell_index_d = LAST_IDX;
                  last_idx_d   = idx_q;
                  idx_d        = '0;
                  state_d      = S_FLUSH;
                  if (in_last != at_last_idx) begin
                     err_len_d = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end
         S_FLUSH: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // The forced top index stands for the true position of the closing beat.
            if (cell_result[DATA_WIDTH-1:0] == LAST_IDX) begin
               res_index_d = last_idx_q;
            end else begin
               res_index_d = cell_result[DATA_WIDTH-1:0];
            end
            if (!cell_result[DATA_WIDTH]) begin
               err_cell_d = 1'b1;
            end
            res_valid_d = 1'b1;
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (res_ready) begin
               res_valid_d   = 1'b0;
               class_count_d = class_count_q + COUNT_ONE;
               state_d       = S_STREAM;
            end
         end
         default: begin
            state_d = S_STREAM;
         end
      endcase
   end

   // State and output registers; reset discards any partial vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_STREAM;
         idx_q         <= '0;
         last_idx_q    <= '0;
         cell_index_q  <= '0;
         cell_value_q  <= '0;
         cell_enable_q <= 1'b0;
         res_index_q   <= '0;
         res_valid_q   <= 1'b0;
         err_len_q     <= 1'b0;
         err_cell_q    <= 1'b0;
         class_count_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         last_idx_q    <= last_idx_d;
         cell_index_q  <= cell_index_d;
         cell_value_q  <= cell_value_d;
         cell_enable_q <= cell_enable_d;
         res_index_q   <= res_index_d;
         res_valid_q   <= res_valid_d;
         err_len_q     <= err_len_d;
         err_cell_q    <= err_cell_d;
         class_count_q <= class_count_d;
      end
   end

   assign cell_index  = cell_index_q;
   assign cell_value  = cell_value_q;
   assign cell_enable = cell_enable_q;
   assign res_index   = res_index_q;
   assign res_valid   = res_valid_q;
   assign err_len     = err_len_q;
   assign err_cell    = err_cell_q;
   assign class_count = class_count_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
// Directed bench: argmax_sequencer driving a softmax_cell, expectations worked out by hand.
// Latency: checks res_valid timing relative to the closing beat.
// Backpressure: exercises stream bubbles and a stalled result consumer.
module tb_argmax_sequencer;

   localparam int DW = 32;
   localparam int CA = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_value;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] cell_index;
   logic [DW-1:0] cell_value;
   logic          cell_enable;
   logic [DW:0]   cell_result;
   logic [DW-1:0] res_index;
   logic          res_valid;
   logic          res_ready;
   logic          err_len;
   logic          err_cell;
   logic          err_clr;
   logic [CW-1:0] class_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   argmax_sequencer #(.DATA_WIDTH(DW), .CELL_AMOUNT(CA), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_value(in_value), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .cell_index(cell_index), .cell_value(cell_value), .cell_enable(cell_enable),
      .cell_result(cell_result),
      .res_index(res_index), .res_valid(res_valid), .res_ready(res_ready),
      .err_len(err_len), .err_cell(err_cell), .err_clr(err_clr),
      .class_count(class_count)
   );

   softmax_cell #(.DATA_WIDTH(DW), .CELL_AMOUNT(CA)) u_cell (
      .clk(clk),
      .input_index(cell_index),
      .input_value(cell_value),
      .input_enable(cell_enable),
      .output_result(cell_result)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns just after the edge that accepts it.
   task automatic beat(input logic [DW-1:0] v, input logic l);
      in_value = v;
      in_last  = l;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) tick();
      check("beat_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Waits a bounded number of cycles for res_valid and checks the index.
   task automatic wait_result(input string tag, input logic [DW-1:0] exp_idx);
      for (int i = 0; i < 8 && !res_valid; i++) tick();
      check({tag, "_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_index"}, 64'(res_index), 64'(exp_idx));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_value  = '0;
      in_last   = 1'b0;
      in_valid  = 1'b0;
      res_ready = 1'b1;
      err_clr   = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_index", 64'(res_index), 64'd0);
      check("rst_cell_enable", 64'(cell_enable), 64'd0);
      check("rst_class_count", 64'(class_count), 64'd0);
      check("rst_err_len", 64'(err_len), 64'd0);
      rst_n = 1'b1;
      tick();
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // Back-to-back 5,9,3,7: max 9 at index 1, exact latency of 2 cycles.
      beat(5, 1'b0);
      check("v1_en0", 64'(cell_enable), 64'd1);
      check("v1_val0", 64'(cell_value), 64'd5);
      check("v1_idx0", 64'(cell_index), 64'd0);
      beat(9, 1'b0);
      check("v1_idx1", 64'(cell_index), 64'd1);
      beat(3, 1'b0);
      beat(7, 1'b1);
      check("v1_idx3", 64'(cell_index), 64'd3);
      check("v1_val3", 64'(cell_value), 64'd7);
      check("v1_flush_ready", 64'(in_ready), 64'd0);
      check("v1_lat0", 64'(res_valid), 64'd0);
      tick();
      check("v1_lat1", 64'(res_valid), 64'd0);
      check("v1_flush_en", 64'(cell_enable), 64'd0);
      tick();
      check("v1_lat2", 64'(res_valid), 64'd1);
      check("v1_res", 64'(res_index), 64'd1);
      tick();
      check("v1_drop", 64'(res_valid), 64'd0);
      check("v1_count", 64'(class_count), 64'd1);
      check("v1_err_len", 64'(err_len), 64'd0);
      check("v1_err_cell", 64'(err_cell), 64'd0);

      // 4,4,2,4 with bubbles: the latest tie (index 3) wins.
      beat(4, 1'b0);
      tick();
      check("v2_bubble0", 64'(cell_enable), 64'd0);
      beat(4, 1'b0);
      tick();
      check("v2_bubble1", 64'(cell_enable), 64'd0);
      beat(2, 1'b0);
      tick();
      beat(4, 1'b1);
      wait_result("v2", 3);
      tick();
      check("v2_count", 64'(class_count), 64'd2);
      check("v2_err_len", 64'(err_len), 64'd0);

      // Short vector 2,8: forced top index, remapped back to 1, length error.
      beat(2, 1'b0);
      beat(8, 1'b1);
      check("v3_forced_idx", 64'(cell_index), 64'd3);
      wait_result("v3", 1);
      check("v3_err_len", 64'(err_len), 64'd1);
      check("v3_err_cell", 64'(err_cell), 64'd0);
      tick();
      check("v3_count", 64'(class_count), 64'd3);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("v3_err_clr", 64'(err_len), 64'd0);

      // Overlong 1,2,3,4 without in_last: closes at index 3, length error.
      beat(1, 1'b0);
      beat(2, 1'b0);
      beat(3, 1'b0);
      beat(4, 1'b0);
      check("v4_closed", 64'(in_ready), 64'd0);
      wait_result("v4", 3);
      check("v4_err_len", 64'(err_len), 64'd1);
      tick();
      check("v4_count", 64'(class_count), 64'd4);

      // Next beat restarts at index 0; result then stalled for 5 cycles.
      res_ready = 1'b0;
      beat(6, 1'b0);
      check("v5_restart_idx", 64'(cell_index), 64'd0);
      beat(1, 1'b0);
      beat(1, 1'b0);
      beat(1, 1'b1);
      wait_result("v5", 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("v5_hold_valid", 64'(res_valid), 64'd1);
         check("v5_hold_index", 64'(res_index), 64'd0);
         check("v5_hold_ready", 64'(in_ready), 64'd0);
         check("v5_hold_count", 64'(class_count), 64'd4);
      end
      res_ready = 1'b1;
      tick();
      check("v5_drop", 64'(res_valid), 64'd0);
      check("v5_count", 64'(class_count), 64'd5);

      // Reset after two beats discards the partial vector.
      beat(3, 1'b0);
      beat(3, 1'b0);
      rst_n = 1'b0;
      #1;
      check("r_in_ready", 64'(in_ready), 64'd0);
      check("r_cell_enable", 64'(cell_enable), 64'd0);
      check("r_cell_index", 64'(cell_index), 64'd0);
      check("r_cell_value", 64'(cell_value), 64'd0);
      check("r_class_count", 64'(class_count), 64'd0);
      check("r_err_len", 64'(err_len), 64'd0);
      check("r_res_valid", 64'(res_valid), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      beat(0, 1'b0);
      check("r_first_idx", 64'(cell_index), 64'd0);
      beat(0, 1'b0);
      beat(6, 1'b0);
      beat(1, 1'b1);
      wait_result("r", 2);
      tick();
      check("r_count", 64'(class_count), 64'd1);
      check("r_err_len_end", 64'(err_len), 64'd0);
      check("r_err_cell_end", 64'(err_cell), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
